// File: rtl/cam_read_port_if.sv
// rtl/cam_read_port_if.sv - request/response handshake bundle for the CAM read port
interface cam_read_port_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [DATA_WIDTH-1:0] rsp_data_o;
   logic                  rsp_err_o;

   modport slave (
      input  req_valid_i, req_addr_i, rsp_ready_i,
      output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
   );

   modport master (
      output req_valid_i, req_addr_i, rsp_ready_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o
   );
endinterface

// File: rtl/cam_read_port.sv
// rtl/cam_read_port.sv - registered CAM read port with 2-entry response queue
// Optional same-cycle write forwarding is enabled by defining CAM_RD_BYPASS_EN.
module cam_read_port #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [DEPTH*DATA_WIDTH-1:0] data_i,
   input  logic                        wr_en_i,
   input  logic [ADDR_WIDTH-1:0]       wr_addr_i,
   input  logic [DATA_WIDTH-1:0]       wr_data_i,
   output logic [15:0]                 rd_count_o,
   cam_read_port_if.slave              bus
);
   localparam int NUM_SLOTS = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_t;

   occ_t                  occ;
   logic [DATA_WIDTH-1:0] q_data [2];
   logic [1:0]            q_err;
   logic                  head;
   logic                  tail;
   logic                  accept;
   logic                  pop;
   logic                  in_range;
   logic [DATA_WIDTH-1:0] cap_data;
   logic [DATA_WIDTH-1:0] entries [NUM_SLOTS];

   // Pad unused address slots with zero so every address value indexes a defined word.
   for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
      if (i < DEPTH) begin : g_used
         assign entries[i] = data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_pad
         assign entries[i] = '0;
      end
   end

   assign in_range = (32'(bus.req_addr_i) < DEPTH);
   assign accept   = bus.req_valid_i & (occ != FULL);
   assign pop      = bus.rsp_ready_i & (occ != EMPTY);
   assign tail     = (occ == ONE) ? ~head : head;

`ifdef CAM_RD_BYPASS_EN
   always_comb begin
      cap_data = in_range ? entries[bus.req_addr_i] : '0;
      if (wr_en_i && (wr_addr_i == bus.req_addr_i) && in_range)
         cap_data = wr_data_i;
   end
`else
   logic unused_wr;
   assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};

   always_comb begin
      cap_data = in_range ? entries[bus.req_addr_i] : '0;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         occ        <= EMPTY;
         head       <= 1'b0;
         q_data[0]  <= '0;
         q_data[1]  <= '0;
         q_err      <= '0;
         rd_count_o <= '0;
      end else begin
         if (accept) begin
            q_data[tail] <= cap_data;
            q_err[tail]  <= ~in_range;
            if (rd_count_o != 16'hFFFF)
               rd_count_o <= rd_count_o + 16'd1;
         end
         if (pop)
            head <= ~head;
         unique case (occ)
            EMPTY: if (accept) occ <= ONE;
            ONE: begin
               if (accept && !pop)
                  occ <= FULL;
               else if (!accept && pop)
                  occ <= EMPTY;
            end
            FULL:    if (pop) occ <= ONE;
            default: occ <= EMPTY;
         endcase
      end
   end

   // Ready depends only on occupancy, so there is no path from rsp_ready_i.
   assign bus.req_ready_o = (occ != FULL);
   assign bus.rsp_valid_o = (occ != EMPTY);
   assign bus.rsp_data_o  = (occ != EMPTY) ? q_data[head] : '0;
   assign bus.rsp_err_o   = (occ != EMPTY) ? q_err[head]  : 1'b0;
endmodule

// File: tb/tb_cam_read_port.sv
// tb/tb_cam_read_port.sv - directed self-checking bench for cam_read_port
module tb_cam_read_port;
   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [15:0] count32;
   logic [15:0] count20;
   logic [31:0] mem   [32];
   logic [31:0] mem20 [20];
   logic [32*32-1:0] data32;
   logic [20*32-1:0] data20;
   int checks = 0;
   int errors = 0;

   cam_read_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus   ();
   cam_read_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus20 ();

   cam_read_port #(.DATA_WIDTH(32), .DEPTH(32)) dut (
      .clk_i(clk), .rst_ni(rst_n), .data_i(data32), .wr_en_i(wr_en),
      .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rd_count_o(count32), .bus(bus)
   );

   cam_read_port #(.DATA_WIDTH(32), .DEPTH(20)) dut20 (
      .clk_i(clk), .rst_ni(rst_n), .data_i(data20), .wr_en_i(wr_en),
      .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rd_count_o(count20), .bus(bus20)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 32; i++) data32[i*32 +: 32] = mem[i];
      for (int j = 0; j < 20; j++) data20[j*32 +: 32] = mem20[j];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
      for (int i = 0; i < 20; i++) mem20[i] = 32'hC000_0000 + i;
      mem[5] = 32'hDEAD_BEEF;
      mem[7] = 32'h1111_1111;
      rst_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.rsp_ready_i = 1'b0;
      bus20.req_valid_i = 1'b0; bus20.req_addr_i = '0; bus20.rsp_ready_i = 1'b0;
      #3;
      chk("rst_valid", bus.rsp_valid_o, 0);
      chk("rst_ready", bus.req_ready_o, 1);
      chk("rst_data", bus.rsp_data_o, 0);
      chk("rst_err", bus.rsp_err_o, 0);
      chk("rst_count", count32, 0);
      tick();
      rst_n = 1'b1;

      // single read
      bus.req_valid_i = 1'b1; bus.req_addr_i = 5'd5;
      tick();
      bus.req_valid_i = 1'b0;
      chk("single_valid", bus.rsp_valid_o, 1);
      chk("single_data", bus.rsp_data_o, 32'hDEAD_BEEF);
      chk("single_err", bus.rsp_err_o, 0);
      chk("single_count", count32, 1);
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
      chk("pop_valid", bus.rsp_valid_o, 0);
      chk("pop_data", bus.rsp_data_o, 0);

      // backpressure
      bus.req_valid_i = 1'b1; bus.req_addr_i = 5'd1;
      tick();
      chk("bp_ready1", bus.req_ready_o, 1);
      bus.req_addr_i = 5'd2;
      tick();
      chk("bp_ready_full", bus.req_ready_o, 0);
      chk("bp_count2", count32, 3);
      bus.req_addr_i = 5'd3;
      tick();
      chk("bp_hold_data", bus.rsp_data_o, mem[1]);
      chk("bp_hold_valid", bus.rsp_valid_o, 1);
      chk("bp_hold_count", count32, 3);
      bus.rsp_ready_i = 1'b1;
      tick();
      chk("bp_resp2", bus.rsp_data_o, mem[2]);
      chk("bp_no_accept", count32, 3);
      chk("bp_ready_again", bus.req_ready_o, 1);
      tick();
      chk("bp_resp3", bus.rsp_data_o, mem[3]);
      chk("bp_count3", count32, 4);
      bus.req_valid_i = 1'b0;
      tick();
      chk("bp_drain", bus.rsp_valid_o, 0);

      // streaming from a fresh reset
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      chk("mid_rst_count", count32, 0);
      for (int i = 0; i < 32; i++) begin
         bus.req_valid_i = 1'b1; bus.req_addr_i = 5'(i);
         tick();
         chk("stream_data", bus.rsp_data_o, mem[i]);
         chk("stream_ready", bus.req_ready_o, 1);
      end
      bus.req_valid_i = 1'b0;
      tick();
      chk("stream_drain", bus.rsp_valid_o, 0);
      chk("stream_count", count32, 32);
      bus.rsp_ready_i = 1'b0;

      // same-cycle write, then a later storage change must not alter the queued entry
      bus.req_valid_i = 1'b1; bus.req_addr_i = 5'd7;
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h2222_2222;
      tick();
      bus.req_valid_i = 1'b0; wr_en = 1'b0;
      mem[7] = 32'h2222_2222;
`ifdef CAM_RD_BYPASS_EN
      chk("bypass_data", bus.rsp_data_o, 32'h2222_2222);
`else
      chk("bypass_data", bus.rsp_data_o, 32'h1111_1111);
`endif
      mem[7] = 32'h3333_3333;
      tick();
`ifdef CAM_RD_BYPASS_EN
      chk("snapshot_data", bus.rsp_data_o, 32'h2222_2222);
`else
      chk("snapshot_data", bus.rsp_data_o, 32'h1111_1111);
`endif
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;

      // out of range on DEPTH=20
      bus20.req_valid_i = 1'b1; bus20.req_addr_i = 5'd25;
      tick();
      chk("oor_data", bus20.rsp_data_o, 0);
      chk("oor_err", bus20.rsp_err_o, 1);
      chk("oor_valid", bus20.rsp_valid_o, 1);
      bus20.rsp_ready_i = 1'b1; bus20.req_addr_i = 5'd3;
      tick();
      chk("after_oor_data", bus20.rsp_data_o, mem20[3]);
      chk("after_oor_err", bus20.rsp_err_o, 0);
      bus20.req_addr_i = 5'd19;
      tick();
      chk("edge19_data", bus20.rsp_data_o, mem20[19]);
      chk("edge19_err", bus20.rsp_err_o, 0);
      bus20.req_addr_i = 5'd20;
      tick();
      chk("edge20_data", bus20.rsp_data_o, 0);
      chk("edge20_err", bus20.rsp_err_o, 1);
      chk("count20", count20, 4);
      bus20.req_valid_i = 1'b0;
      tick();
      chk("oor_drain", bus20.rsp_valid_o, 0);

      // reset with a full queue and a request pending
      bus.req_valid_i = 1'b1; bus.req_addr_i = 5'd1;
      tick();
      bus.req_addr_i = 5'd2;
      tick();
      chk("full_ready", bus.req_ready_o, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", bus.rsp_valid_o, 0);
      chk("arst_ready", bus.req_ready_o, 1);
      chk("arst_data", bus.rsp_data_o, 0);
      chk("arst_count", count32, 0);
      tick();
      bus.req_valid_i = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("arst_dropped", bus.rsp_valid_o, 0);

      // saturation
      bus.rsp_ready_i = 1'b1; bus.req_valid_i = 1'b1; bus.req_addr_i = 5'd0;
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_minus1", count32, 16'hFFFE);
      tick();
      chk("sat_reach", count32, 16'hFFFF);
      tick();
      tick();
      chk("sat_hold", count32, 16'hFFFF);
      chk("sat_stream_data", bus.rsp_data_o, mem[0]);
      bus.req_valid_i = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
